// File: rtl/status_led_sequencer.sv
// Status LED sequencer: bounce, rotate, blink and error-code display
// modes, stepped by a programmable prescaler.
module status_led_sequencer #(
  parameter int unsigned NUM_LEDS    = 8,
  parameter int unsigned TICK_DIV    = 3000000,
  parameter int unsigned PAUSE_STEPS = 4
) (
  input  logic                clock,
  input  logic                nReset,
  input  logic [1:0]          mode,
  input  logic [3:0]          errorCode,
  input  logic                hold,
  output logic [NUM_LEDS-1:0] leds,
  output logic                stepPulse
);

  localparam int PW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [PW-1:0] LAST = PW'(NUM_LEDS - 1);
  localparam logic [31:0] TMAX = 32'(TICK_DIV - 1);
  localparam logic [3:0] PMAX = 4'(PAUSE_STEPS);
  localparam logic [NUM_LEDS-1:0] ONE = NUM_LEDS'(1);

  typedef enum logic [2:0] {
    E_IDLE,
    E_LATCH,
    E_ON,
    E_OFF,
    E_PAUSE
  } estate_t;

  logic [31:0]   cnt, cnt_n;
  logic [PW-1:0] pos, pos_n, nxt;
  logic          down, down_n;
  logic [1:0]    modeReg;
  estate_t       est, est_n;
  logic [3:0]    rem, rem_n;
  logic [3:0]    pauseCnt, pause_n;
  logic [NUM_LEDS-1:0] leds_n;
  logic          pulse_n;
  logic          modeChg;
  logic          tick;

  assign modeChg = (mode != modeReg);
  assign tick = !hold && (cnt == TMAX);

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      cnt       <= '0;
      pos       <= '0;
      down      <= 1'b0;
      modeReg   <= 2'd0;
      est       <= E_IDLE;
      rem       <= '0;
      pauseCnt  <= '0;
      leds      <= ONE;
      stepPulse <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      pos       <= pos_n;
      down      <= down_n;
      modeReg   <= mode;
      est       <= est_n;
      rem       <= rem_n;
      pauseCnt  <= pause_n;
      leds      <= leds_n;
      stepPulse <= pulse_n;
    end
  end

  always_comb begin
    cnt_n   = cnt;
    pos_n   = pos;
    down_n  = down;
    est_n   = est;
    rem_n   = rem;
    pause_n = pauseCnt;
    leds_n  = leds;
    pulse_n = 1'b0;
    nxt     = pos;
    if (modeChg) begin
      // restart from the entry pattern of the incoming mode
      cnt_n   = '0;
      pos_n   = '0;
      down_n  = 1'b0;
      est_n   = E_LATCH;
      rem_n   = '0;
      pause_n = '0;
      unique case (mode)
        2'd2:    leds_n = '1;
        2'd3:    leds_n = '0;
        default: leds_n = ONE;
      endcase
    end else if (!hold) begin
      cnt_n = tick ? 32'd0 : cnt + 32'd1;
      if (tick) begin
        pulse_n = 1'b1;
        unique case (modeReg)
          2'd0: begin
            if (NUM_LEDS == 1) begin
              leds_n = ONE;
            end else begin
              nxt = down ? pos - 1'b1 : pos + 1'b1;
              pos_n = nxt;
              if (nxt == LAST) down_n = 1'b1;
              else if (nxt == '0) down_n = 1'b0;
              leds_n = ONE << nxt;
            end
          end
          2'd1: begin
            nxt = (pos == LAST) ? '0 : pos + 1'b1;
            pos_n = nxt;
            leds_n = ONE << nxt;
          end
          2'd2: begin
            leds_n = (leds == '1) ? '0 : '1;
          end
          default: begin
            unique case (est)
              E_IDLE, E_LATCH: begin
                if (errorCode == 4'd0) begin
                  est_n = E_LATCH;
                  leds_n = '0;
                end else begin
                  est_n = E_ON;
                  leds_n = '1;
                  rem_n = errorCode;
                end
              end
              E_ON: begin
                est_n = E_OFF;
                leds_n = '0;
                rem_n = rem - 4'd1;
              end
              E_OFF: begin
                if (rem != 4'd0) begin
                  est_n = E_ON;
                  leds_n = '1;
                end else begin
                  est_n = E_PAUSE;
                  pause_n = 4'd1;
                  leds_n = '0;
                end
              end
              E_PAUSE: begin
                leds_n = '0;
                if (pauseCnt == PMAX) est_n = E_LATCH;
                else pause_n = pauseCnt + 4'd1;
              end
              default: begin
                est_n = E_LATCH;
                leds_n = '0;
              end
            endcase
          end
        endcase
      end
    end
  end

endmodule
